// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port sync RAM between fetch and load/store; data has priority, starvation-bounded.
// 3-cycle access (grant, issue, respond), no overlap; requesters hold req until ack and see stall meanwhile.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req_i,
    input  logic [ADDR_W-1:0]   inst_addr_i,
    output logic [DATA_W-1:0]   inst_data_o,
    output logic                inst_ack_o,
    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic [DATA_W/8-1:0] data_sel_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_ack_o,
    input  logic                flush_i,
    output logic                stall_if_o,
    output logic                stall_mem_o,
    output logic                mem_ce_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0] mem_sel_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);
    localparam int SEL_W = DATA_W / 8;
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

    state_t           state;
    logic             gnt_inst;
    logic             flush_pend;
    logic [CNT_W-1:0] starve_cnt;
    logic             gnt_data_c;
    logic             gnt_inst_c;

    // Data wins unless fetch has already been passed over STARVE_LIMIT times in a row.
    assign gnt_data_c = data_req_i && !(inst_req_i && (starve_cnt == CNT_MAX));
    assign gnt_inst_c = inst_req_i && !gnt_data_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            gnt_inst    <= 1'b0;
            flush_pend  <= 1'b0;
            starve_cnt  <= '0;
            mem_ce_o    <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_sel_o   <= '0;
            mem_wdata_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!inst_req_i || gnt_inst_c) begin
                        starve_cnt <= '0;
                    end else if (starve_cnt != CNT_MAX) begin
                        starve_cnt <= starve_cnt + CNT_W'(1);
                    end
                    if (gnt_inst_c) begin
                        state       <= ISSUE;
                        gnt_inst    <= 1'b1;
                        flush_pend  <= flush_i;
                        mem_ce_o    <= 1'b1;
                        mem_we_o    <= 1'b0;
                        mem_addr_o  <= inst_addr_i;
                        mem_sel_o   <= {SEL_W{1'b1}};
                        mem_wdata_o <= '0;
                    end else if (gnt_data_c) begin
                        state       <= ISSUE;
                        gnt_inst    <= 1'b0;
                        mem_ce_o    <= 1'b1;
                        mem_we_o    <= data_we_i;
                        mem_addr_o  <= data_addr_i;
                        mem_sel_o   <= data_sel_i;
                        mem_wdata_o <= data_wdata_i;
                    end
                end
                ISSUE: begin
                    state       <= RESP;
                    mem_ce_o    <= 1'b0;
                    mem_we_o    <= 1'b0;
                    mem_addr_o  <= '0;
                    mem_sel_o   <= '0;
                    mem_wdata_o <= '0;
                    if (gnt_inst && flush_i) begin
                        flush_pend <= 1'b1;
                    end
                end
                RESP: begin
                    state      <= IDLE;
                    flush_pend <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A flush seen in the response cycle itself must still squash the fetch ack.
    assign inst_ack_o   = (state == RESP) && gnt_inst && !flush_pend && !flush_i;
    assign data_ack_o   = (state == RESP) && !gnt_inst;
    assign inst_data_o  = inst_ack_o ? mem_rdata_i : '0;
    assign data_rdata_o = data_ack_o ? mem_rdata_i : '0;
    assign stall_if_o   = inst_req_i && !inst_ack_o;
    assign stall_mem_o  = data_req_i && !data_ack_o;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push expected memory cycles and acks,
// a negedge monitor pops and compares whenever the DUT drives the memory or acks a requester.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_data_o;
    logic        inst_ack_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [31:0] data_addr_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_ack_o;
    logic        flush_i;
    logic        stall_if_o;
    logic        stall_mem_o;
    logic        mem_ce_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [3:0]  mem_sel_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i),
        .inst_data_o(inst_data_o), .inst_ack_o(inst_ack_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_addr_i(data_addr_i),
        .data_sel_i(data_sel_i), .data_wdata_i(data_wdata_i),
        .data_rdata_o(data_rdata_o), .data_ack_o(data_ack_o),
        .flush_i(flush_i), .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o),
        .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_sel_o(mem_sel_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Synchronous RAM: read data appears the cycle after ce is sampled.
    logic [31:0] tmem [logic [31:0]];
    logic [31:0] rdata_q = 32'h0;
    logic [31:0] wtmp;
    assign mem_rdata_i = rdata_q;
    always @(posedge clk) begin
        if (mem_ce_o) begin
            if (mem_we_o) begin
                wtmp = tmem.exists(mem_addr_o) ? tmem[mem_addr_o] : 32'h0;
                for (int b = 0; b < 4; b++)
                    if (mem_sel_o[b]) wtmp[8*b +: 8] = mem_wdata_o[8*b +: 8];
                tmem[mem_addr_o] = wtmp;
            end else begin
                rdata_q <= tmem.exists(mem_addr_o) ? tmem[mem_addr_o] : 32'h0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic we; logic [31:0] addr; logic [3:0] sel; logic [31:0] wdata; } mem_exp_t;
    typedef struct { int cyc; bit is_inst; bit chk; logic [31:0] data; } ack_exp_t;
    mem_exp_t mem_q[$];
    ack_exp_t ack_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_mem(input int c, input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
        mem_exp_t e;
        e.cyc = c; e.we = we; e.addr = a; e.sel = s; e.wdata = wd;
        mem_q.push_back(e);
    endtask

    task automatic push_ack(input int c, input bit is_inst, input bit chk, input logic [31:0] d);
        ack_exp_t e;
        e.cyc = c; e.is_inst = is_inst; e.chk = chk; e.data = d;
        ack_q.push_back(e);
    endtask

    task automatic handle_ack(input bit is_inst, input logic [31:0] d);
        ack_exp_t e;
        if (ack_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_ack: got %s ack at cycle %0d, required none", is_inst ? "inst" : "data", cyc);
        end else begin
            e = ack_q.pop_front();
            check("ack_kind_cycle", {95'(is_inst), 32'(cyc)}, {95'(e.is_inst), 32'(e.cyc)});
            if (e.chk) check("ack_data", 128'(d), 128'(e.data));
        end
    endtask

    // Monitor
    initial begin
        mem_exp_t m;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("stall_if", 128'(stall_if_o), 128'(inst_req_i && !inst_ack_o));
                check("stall_mem", 128'(stall_mem_o), 128'(data_req_i && !data_ack_o));
            end
            if (mem_ce_o) begin
                if (mem_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_mem: got access to %0h at cycle %0d, required none", mem_addr_o, cyc);
                end else begin
                    m = mem_q.pop_front();
                    check("mem_access",
                          {32'(cyc), mem_we_o, mem_addr_o, mem_sel_o, mem_we_o ? mem_wdata_o : 32'h0},
                          {32'(m.cyc), m.we, m.addr, m.sel, m.we ? m.wdata : 32'h0});
                end
            end
            if (inst_ack_o) handle_ack(1'b1, inst_data_o);
            if (data_ack_o) handle_ack(1'b0, data_rdata_o);
        end
    end

    task automatic wait_ack(input bit is_inst, input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_inst ? inst_ack_o : data_ack_o) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            tests++; fails++;
            $display("FAIL %s: got no ack within 40 cycles, required an ack", name);
        end
    endtask

    task automatic fetch(input logic [31:0] a);
        inst_addr_i = a;
        inst_req_i  = 1'b1;
        wait_ack(1'b1, "fetch_timeout");
        @(posedge clk); #1;
        inst_req_i = 1'b0;
    endtask

    task automatic data_access(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd);
        data_we_i = we; data_addr_i = a; data_sel_i = s; data_wdata_i = wd;
        data_req_i = 1'b1;
        wait_ack(1'b0, "data_timeout");
        @(posedge clk); #1;
        data_req_i = 1'b0;
    endtask

    task automatic data_burst();
        data_we_i = 1'b0; data_sel_i = 4'hF; data_wdata_i = 32'h0;
        data_req_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_addr_i = 32'h300 + 32'(4 * k);
            wait_ack(1'b0, "burst_timeout");
            @(posedge clk); #1;
        end
        data_req_i = 1'b0;
    endtask

    int t;

    initial begin
        rst = 1'b1;
        inst_req_i = 1'b0; inst_addr_i = 32'h0;
        data_req_i = 1'b0; data_we_i = 1'b0; data_addr_i = 32'h0;
        data_sel_i = 4'h0; data_wdata_i = 32'h0; flush_i = 1'b0;
        tmem[32'h10]  = 32'h2401_0005;
        tmem[32'h14]  = 32'h0000_0013;
        tmem[32'h18]  = 32'hBAD0_0018;
        tmem[32'h40]  = 32'hCAFE_0040;
        tmem[32'h100] = 32'h1234_5678;
        tmem[32'h200] = 32'h1111_1111;
        for (int k = 0; k < 5; k++) tmem[32'h300 + 32'(4 * k)] = 32'hA000_0000 + 32'(k);

        repeat (2) @(posedge clk); #1;
        check("reset_outputs",
              {mem_ce_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o, inst_ack_o, data_ack_o, stall_if_o, stall_mem_o},
              128'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single fetch
        t = cyc;
        push_mem(t + 1, 1'b0, 32'h10, 4'hF, 32'h0);
        push_ack(t + 2, 1'b1, 1'b1, 32'h2401_0005);
        fetch(32'h10);

        // Simultaneous fetch and load: data first
        t = cyc;
        push_mem(t + 1, 1'b0, 32'h100, 4'hF, 32'h0);
        push_ack(t + 2, 1'b0, 1'b1, 32'h1234_5678);
        push_mem(t + 4, 1'b0, 32'h14, 4'hF, 32'h0);
        push_ack(t + 5, 1'b1, 1'b1, 32'h0000_0013);
        fork
            fetch(32'h14);
            data_access(1'b0, 32'h100, 4'hF, 32'h0);
        join

        // Partial store, then read back the merged word
        t = cyc;
        push_mem(t + 1, 1'b1, 32'h200, 4'b0011, 32'hDEAD_BEEF);
        push_ack(t + 2, 1'b0, 1'b0, 32'h0);
        data_access(1'b1, 32'h200, 4'b0011, 32'hDEAD_BEEF);
        t = cyc;
        push_mem(t + 1, 1'b0, 32'h200, 4'hF, 32'h0);
        push_ack(t + 2, 1'b0, 1'b1, 32'h1111_BEEF);
        data_access(1'b0, 32'h200, 4'hF, 32'h0);

        // Starvation: four data grants, then the fetch, then the last data access
        t = cyc;
        for (int k = 0; k < 4; k++) begin
            push_mem(t + 1 + 3 * k, 1'b0, 32'h300 + 32'(4 * k), 4'hF, 32'h0);
            push_ack(t + 2 + 3 * k, 1'b0, 1'b1, 32'hA000_0000 + 32'(k));
        end
        push_mem(t + 13, 1'b0, 32'h40, 4'hF, 32'h0);
        push_ack(t + 14, 1'b1, 1'b1, 32'hCAFE_0040);
        push_mem(t + 16, 1'b0, 32'h310, 4'hF, 32'h0);
        push_ack(t + 17, 1'b0, 1'b1, 32'hA000_0004);
        fork
            data_burst();
            fetch(32'h40);
            begin
                repeat (12) @(posedge clk); #1;
                check("starve_saturated", 128'(dut.starve_cnt), 128'd4);
                @(posedge clk); #1;
                check("starve_cleared", 128'(dut.starve_cnt), 128'd0);
            end
        join

        // Flush during ISSUE: access happens, ack suppressed
        t = cyc;
        push_mem(t + 1, 1'b0, 32'h18, 4'hF, 32'h0);
        inst_addr_i = 32'h18;
        inst_req_i  = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i    = 1'b0;
        inst_req_i = 1'b0;
        check("flush_no_ack", 128'(inst_ack_o), 128'd0);
        @(posedge clk); #1;
        t = cyc;
        push_mem(t + 1, 1'b0, 32'h14, 4'hF, 32'h0);
        push_ack(t + 2, 1'b1, 1'b1, 32'h0000_0013);
        fetch(32'h14);

        // Reset during ISSUE abandons the access
        inst_addr_i = 32'h10;
        inst_req_i  = 1'b1;
        @(posedge clk); #1;
        check("ce_before_reset", 128'(mem_ce_o), 128'd1);
        rst = 1'b1;
        inst_req_i = 1'b0;
        #1;
        check("reset_mid_access", {mem_ce_o, mem_we_o, inst_ack_o, data_ack_o}, 128'h0);
        check("reset_state_idle", 128'(dut.state), 128'd0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk); #1;
        t = cyc;
        push_mem(t + 1, 1'b0, 32'h10, 4'hF, 32'h0);
        push_ack(t + 2, 1'b1, 1'b1, 32'h2401_0005);
        fetch(32'h10);

        repeat (5) @(posedge clk); #1;
        check("mem_queue_drained", 128'(mem_q.size()), 128'd0);
        check("ack_queue_drained", 128'(ack_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
